// File: rtl/elm_pkg.sv
// Shared definitions for the ELM hidden-layer sequencer: state encoding,
// default geometry and the width helpers used to size the counters.
package elm_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CLR  = 3'd1;
  localparam logic [2:0] ST_MAC  = 3'd2;
  localparam logic [2:0] ST_ACT  = 3'd3;
  localparam logic [2:0] ST_WB   = 3'd4;
  localparam logic [2:0] ST_FIN  = 3'd5;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    CLR  = ST_CLR,
    MAC  = ST_MAC,
    ACT  = ST_ACT,
    WB   = ST_WB,
    FIN  = ST_FIN
  } state_t;

  localparam int N_IN_DEF    = 32'sd16;
  localparam int N_HID_DEF   = 32'sd32;
  localparam int ACT_LAT_DEF = 32'sd2;

  function automatic int clog2(input int v);
    int r;
    r = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd2 ** i) < v) begin
        r = i + 32'sd1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // A modulo-1 counter still needs one physical bit.
  function automatic int idx_w(input int n);
    return (clog2(n) < 32'sd1) ? 32'sd1 : clog2(n);
  endfunction

endpackage

// File: rtl/elm_idx_counter.sv
// Modulo-N index counter with synchronous clear; terminal is the carry out of
// an offset add, so it rises exactly when value == N-1 for any N.
module elm_idx_counter
  import elm_pkg::*;
#(
  parameter int N = 16,
  parameter int W = idx_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         terminal
);

  localparam int            OFS    = (2 ** W) - N + 1;
  localparam logic [W:0]    OFS_V  = OFS[W:0];
  localparam int            OFS_M1 = (2 ** W) - N;
  localparam logic [W-1:0]  OFS_M1_V = OFS_M1[W-1:0];

  logic [W-1:0] value_r;
  logic [W:0]   sum_s;
  logic [W-1:0] next_s;

  // Offset domain: the add carries out at N-1, and removing OFS-1 gives value+1.
  always_comb begin
    sum_s    = {1'b0, value_r} + OFS_V;
    next_s   = sum_s[W-1:0] - OFS_M1_V;
    terminal = sum_s[W];
  end

  // Index register: clear wins over increment, wrap to zero at the terminal value.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_r <= '0;
    end else if (clr) begin
      value_r <= '0;
    end else if (inc) begin
      value_r <= terminal ? '0 : next_s;
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;

endmodule

// File: rtl/elm_hidden_sequencer.sv
// Control FSM for the ELM hidden layer: walks N_HID neurons through
// clear / multiply-accumulate / activation / write-back on the shared datapath.
module elm_hidden_sequencer
  import elm_pkg::*;
#(
  parameter int N_IN    = N_IN_DEF,
  parameter int N_HID   = N_HID_DEF,
  parameter int ACT_LAT = ACT_LAT_DEF,
  parameter int IN_W    = clog2(N_IN),
  parameter int HID_W   = idx_w(N_HID),
  parameter int ADDR_W  = clog2(N_IN * N_HID)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              busy,
  output logic              done,
  output logic              acc_clr,
  output logic              mac_en,
  output logic [IN_W-1:0]   in_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              act_en,
  output logic              h_we,
  output logic [HID_W-1:0]  h_addr
);

  localparam int WT_W = idx_w(ACT_LAT);

  state_t            state_r;
  state_t            state_s;
  logic              cnt_clr_s;
  logic              in_inc_s;
  logic              hid_inc_s;
  logic              wt_inc_s;
  logic              w_inc_s;
  logic              in_term_s;
  logic              hid_term_s;
  logic              wt_term_s;
  logic [WT_W-1:0]   wt_val_s;
  logic [ADDR_W-1:0] w_addr_r;

  elm_idx_counter #(.N(N_IN), .W(IN_W)) u_in_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr_s),
    .inc      (in_inc_s),
    .value    (in_addr),
    .terminal (in_term_s)
  );

  elm_idx_counter #(.N(N_HID), .W(HID_W)) u_hid_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr_s),
    .inc      (hid_inc_s),
    .value    (h_addr),
    .terminal (hid_term_s)
  );

  elm_idx_counter #(.N(ACT_LAT), .W(WT_W)) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr_s),
    .inc      (wt_inc_s),
    .value    (wt_val_s),
    .terminal (wt_term_s)
  );

  // Next-state and counter-control decode; abort from any busy state overrides the walk.
  always_comb begin
    state_s   = state_r;
    cnt_clr_s = 1'b0;
    in_inc_s  = 1'b0;
    hid_inc_s = 1'b0;
    wt_inc_s  = 1'b0;
    w_inc_s   = 1'b0;
    if (abort && (state_r != IDLE)) begin
      state_s   = IDLE;
      cnt_clr_s = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_s   = CLR;
            cnt_clr_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        CLR: state_s = MAC;
        MAC: begin
          if (in_valid) begin
            in_inc_s = 1'b1;
            // Hold on the very last weight so w_addr never wraps mid-pass.
            w_inc_s  = !(in_term_s && hid_term_s);
            state_s  = in_term_s ? ACT : MAC;
          end else begin
            state_s = MAC;
          end
        end
        ACT: begin
          wt_inc_s = 1'b1;
          state_s  = wt_term_s ? WB : ACT;
        end
        WB: begin
          if (hid_term_s) begin
            state_s = FIN;
          end else begin
            hid_inc_s = 1'b1;
            state_s   = CLR;
          end
        end
        FIN: state_s = IDLE;
        default: begin
          state_s   = IDLE;
          cnt_clr_s = 1'b1;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Weight address runs alongside the input index across neuron boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_addr_r <= '0;
    end else if (cnt_clr_s) begin
      w_addr_r <= '0;
    end else if (w_inc_s) begin
      w_addr_r <= w_addr_r + ADDR_W'(1);
    end else begin
      w_addr_r <= w_addr_r;
    end
  end

  assign busy    = (state_r != IDLE);
  assign done    = (state_r == FIN);
  assign acc_clr = (state_r == CLR);
  assign mac_en  = (state_r == MAC) && in_valid;
  assign act_en  = (state_r == ACT) && (wt_val_s == '0);
  assign h_we    = (state_r == WB);
  assign w_addr  = w_addr_r;

endmodule

// File: tb/tb_elm_hidden_sequencer.sv
// Scoreboard bench: each pass pushes its expected strobe events, and a monitor
// per DUT pops and compares whenever a strobe appears.
module tb_elm_hidden_sequencer;

  typedef struct {
    int cyc;
    int kind;
    int ia;
    int wa;
    int ha;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic       busy, done, acc_clr, mac_en, act_en, h_we;
  logic [3:0] in_addr;
  logic [8:0] w_addr;
  logic [4:0] h_addr;

  logic       start_b = 1'b0, abort_b = 1'b0, in_valid_b = 1'b1;
  logic       busy_b, done_b, acc_clr_b, mac_en_b, act_en_b, h_we_b;
  logic [1:0] in_addr_b;
  logic [1:0] w_addr_b;
  logic [0:0] h_addr_b;

  elm_hidden_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid),
    .busy(busy), .done(done), .acc_clr(acc_clr), .mac_en(mac_en),
    .in_addr(in_addr), .w_addr(w_addr), .act_en(act_en), .h_we(h_we), .h_addr(h_addr)
  );

  elm_hidden_sequencer #(.N_IN(4), .N_HID(1), .ACT_LAT(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .in_valid(in_valid_b),
    .busy(busy_b), .done(done_b), .acc_clr(acc_clr_b), .mac_en(mac_en_b),
    .in_addr(in_addr_b), .w_addr(w_addr_b), .act_en(act_en_b), .h_we(h_we_b), .h_addr(h_addr_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int which, input int c, input int k, input int ia, input int wa, input int ha);
    ev_t e;
    e = '{c, k, ia, wa, ha};
    if (which == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Expected strobes for one pass (kinds: 0 clr, 1 mac, 2 act, 3 wb, 4 done).
  task automatic gen(input int which, input int t, input int nin, input int nhid, input int alat,
                     input int sn, input int si, input int sc, input int stop);
    int c, wl, wa;
    c  = t + 1;
    wl = nin * nhid - 1;
    for (int n = 0; n < nhid; n++) begin
      if (c <= stop) push(which, c, 0, 0, n * nin, n);
      c++;
      for (int i = 0; i < nin; i++) begin
        if (n == sn && i == si) c += sc;
        if (c <= stop) push(which, c, 1, i, n * nin + i, n);
        c++;
      end
      wa = (n == nhid - 1) ? wl : (n + 1) * nin;
      if (c <= stop) push(which, c, 2, 0, wa, n);
      c += alat;
      if (c <= stop) push(which, c, 3, 0, wa, n);
      c++;
    end
    if (c <= stop) push(which, c, 4, 0, wl, nhid - 1);
  endtask

  task automatic check_ev(input int which, input logic [4:0] st, input int ia, input int wa,
                          input int ha, input logic bz);
    int  k;
    ev_t e;
    if (st == 5'b0) return;
    checks++;
    k = st[0] ? 0 : st[1] ? 1 : st[2] ? 2 : st[3] ? 3 : 4;
    if ($countones(st) != 1 || bz !== 1'b1) begin
      errors++;
      $display("FAIL excl_busy[%0d] cyc=%0d: strobes=%b busy=%b, required one strobe with busy=1",
               which, cyc, st, bz);
    end
    if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL unexpected[%0d] cyc=%0d: strobes=%b ia=%0d wa=%0d ha=%0d, required no strobe",
               which, cyc, st, ia, wa, ha);
      return;
    end
    e = (which == 0) ? q0.pop_front() : q1.pop_front();
    if (e.cyc != cyc || e.kind != k || e.ia != ia || e.wa != wa || e.ha != ha) begin
      errors++;
      $display("FAIL event[%0d]: got cyc=%0d kind=%0d ia=%0d wa=%0d ha=%0d, required cyc=%0d kind=%0d ia=%0d wa=%0d ha=%0d",
               which, cyc, k, ia, wa, ha, e.cyc, e.kind, e.ia, e.wa, e.ha);
    end
  endtask

  always @(negedge clk) if (cyc > 0) check_ev(0, {done, h_we, act_en, mac_en, acc_clr}, in_addr, w_addr, h_addr, busy);
  always @(negedge clk) if (cyc > 0) check_ev(1, {done_b, h_we_b, act_en_b, mac_en_b, acc_clr_b}, in_addr_b, w_addr_b, h_addr_b, busy_b);

  task automatic check_zero(input string nm);
    checks++;
    if ({busy, done, acc_clr, mac_en, act_en, h_we} !== 6'b0 || in_addr !== 4'd0 ||
        w_addr !== 9'd0 || h_addr !== 5'd0) begin
      errors++;
      $display("FAIL %s cyc=%0d: busy=%b done=%b clr=%b mac=%b act=%b we=%b ia=%0d wa=%0d ha=%0d, required all 0",
               nm, cyc, busy, done, acc_clr, mac_en, act_en, h_we, in_addr, w_addr, h_addr);
    end
  endtask

  // One default-geometry pass: optional stall, abort or reset at a cycle offset from start.
  task automatic pass_a(input int sn, input int si, input int sc, input int abort_rel,
                        input int rst_rel, input int hold);
    int t, stop, ss, dn, cur;
    bit cut;
    @(posedge clk); #1;
    t = cyc; start = 1'b1; in_valid = 1'b1;
    cut  = (abort_rel >= 0) || (rst_rel >= 0);
    stop = (abort_rel >= 0) ? t + abort_rel : (rst_rel >= 0) ? t + rst_rel : 32'sd1 << 30;
    gen(0, t, 16, 32, 2, sn, si, sc, stop);
    ss = t + 2 + sn * 20 + si;
    dn = t + 641 + sc;
    if (!cut) stop = dn;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      cur      = cyc;
      start    = (cur < t + hold);
      in_valid = !(cur >= ss && cur < ss + sc);
      abort    = (abort_rel >= 0 && cur == stop);
      rst      = (rst_rel >= 0 && cur == stop);
      if (!in_valid) begin
        @(negedge clk);
        checks++;
        if (mac_en !== 1'b0 || in_addr !== si[3:0] || w_addr !== 9'(sn * 16 + si)) begin
          errors++;
          $display("FAIL stall cyc=%0d: mac_en=%b ia=%0d wa=%0d, required 0 %0d %0d",
                   cyc, mac_en, in_addr, w_addr, si, sn * 16 + si);
        end
      end
      if (cur == stop + 1) break;
    end
    @(negedge clk);
    if (cut) begin
      check_zero("cut_zero");
    end else begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || cyc != dn + 1) begin
        errors++;
        $display("FAIL busy_fall cyc=%0d: busy=%b done=%b, required cyc=%0d busy=0 done=0",
                 cyc, busy, done, dn + 1);
      end
    end
    #1;
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL pending_a: %0d events left, required 0 (next cyc=%0d kind=%0d)",
               q0.size(), q0[0].cyc, q0[0].kind);
      q0.delete();
    end
  endtask

  task automatic pass_b();
    int t;
    @(posedge clk); #1;
    t = cyc; start_b = 1'b1;
    gen(1, t, 4, 1, 1, -1, 0, 0, 32'sd1 << 30);
    @(posedge clk); #1;
    start_b = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy_b !== 1'b0 || cyc != t + 9) begin
      errors++;
      $display("FAIL busy_fall_b cyc=%0d: busy=%b, required cyc=%0d busy=0", cyc, busy_b, t + 9);
    end
    #1;
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL pending_b: %0d events left, required 0", q1.size());
      q1.delete();
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("reset_a");
    checks++;
    if ({busy_b, done_b, acc_clr_b, mac_en_b, act_en_b, h_we_b} !== 6'b0 ||
        in_addr_b !== 2'd0 || w_addr_b !== 2'd0 || h_addr_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: busy=%b ia=%0d wa=%0d ha=%0d, required all 0",
               busy_b, in_addr_b, w_addr_b, h_addr_b);
    end
    pass_a(-1, 0, 0, -1, -1, 1);
    pass_a(5, 7, 3, -1, -1, 1);
    pass_a(-1, 0, 0, 218, -1, 1);
    pass_a(-1, 0, 0, -1, -1, 1);
    pass_a(-1, 0, 0, -1, 66, 1);
    pass_a(-1, 0, 0, -1, -1, 50);
    pass_b();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
